// File: rtl/dac_spi_tx_pkg.sv
// Shared definitions for the MCP4911 SPI transmitter: FSM encoding, DAC
// configuration constants and the frame-word builder.
package dac_spi_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CSHI  = 2'd2,
    ST_LDAC  = 2'd3
  } dac_state_e;

  // MCP4911 word[15:12]: A/B=0, BUF=0, GA_n=1 (1x gain), SHDN_n=1 (active)
  localparam logic [3:0] MCP_CFG_DEFAULT = 4'b0011;
  localparam logic [9:0] DAC_OFFSET      = 10'h200;
  localparam logic [5:0] HALF_LAST       = 6'd31;

  function automatic logic [15:0] mcp_word(input logic [3:0] cfg, input logic [9:0] sample);
    return {cfg, sample, 2'b00};
  endfunction

endpackage

// File: rtl/dac_spi_tx_tick_gen.sv
// Half-period timer: counts 0..CLK_DIV-1 while enabled and flags the
// terminal-count cycle; a clear holds it at zero.
module dac_spi_tx_tick_gen #(
  parameter int CLK_DIV = 25,
  localparam int CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          clr_i,
  output logic          tick_o,
  output logic [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == TC);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises 10-bit samples into 16-bit MCP4911 SPI frames (mode 0, MSB first)
// followed by an LDAC strobe, with a one-deep pending buffer.
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int         CLK_DIV  = 25,
  parameter logic [3:0] CFG_BITS = MCP_CFG_DEFAULT
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun,
  output logic       dac_cs_n,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld_n
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DONE_CNT = CW'(CLK_DIV - 2);

  dac_state_e  state_q, state_d;
  logic [5:0]  half_q, half_d;
  logic [15:0] sr_q, sr_d;
  logic [9:0]  pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        ovr_q, ovr_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        sdi_q, sdi_d;
  logic        ld_n_q, ld_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic          tick;
  logic [CW-1:0] cnt;

  dac_spi_tx_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (sysclk),
    .rst_i  (reset),
    .en_i   (state_q != ST_IDLE),
    .clr_i  (state_q == ST_IDLE),
    .tick_o (tick),
    .cnt_o  (cnt)
  );

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    sr_d       = sr_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovr_d      = ovr_q;

    case (state_q)
      ST_IDLE: begin
        half_d = '0;
        // A fresh load beats an older pending word.
        if (load) begin
          sr_d       = mcp_word(CFG_BITS, data_in);
          pend_vld_d = 1'b0;
          state_d    = ST_SHIFT;
        end else if (pend_vld_q) begin
          sr_d       = mcp_word(CFG_BITS, pend_q);
          pend_vld_d = 1'b0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (half_q[0]) begin
            sr_d = {sr_q[14:0], 1'b0};
          end
          if (half_q == HALF_LAST) begin
            half_d  = '0;
            state_d = ST_CSHI;
          end else begin
            half_d = half_q + 6'd1;
          end
        end
      end
      ST_CSHI: begin
        if (tick) begin
          state_d = ST_LDAC;
        end
      end
      ST_LDAC: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load && (state_q != ST_IDLE)) begin
      pend_d     = data_in;
      pend_vld_d = 1'b1;
      if (pend_vld_q) begin
        ovr_d = 1'b1;
      end
    end

    // Pins are driven from next-state values so they can be registered
    // without lagging the FSM by a cycle.
    busy_d = (state_d != ST_IDLE);
    cs_n_d = (state_d != ST_SHIFT);
    sck_d  = (state_d == ST_SHIFT) && half_d[0];
    sdi_d  = (state_d == ST_SHIFT) && sr_d[15];
    ld_n_d = (state_d != ST_LDAC);
    done_d = (state_q == ST_LDAC) && (cnt == DONE_CNT);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      half_q     <= '0;
      sr_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovr_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      sck_q      <= 1'b0;
      sdi_q      <= 1'b0;
      ld_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      sr_q       <= sr_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovr_q      <= ovr_d;
      cs_n_q     <= cs_n_d;
      sck_q      <= sck_d;
      sdi_q      <= sdi_d;
      ld_n_q     <= ld_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_sck    = sck_q;
  assign dac_sdi    = sdi_q;
  assign dac_ld_n   = ld_n_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: default CLK_DIV=25 instance plus a CLK_DIV=2 instance.
module tb_dac_spi_tx;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic [9:0] data_in = '0;
  logic       load0 = 1'b0;
  logic       load1 = 1'b0;

  logic busy0, fd0, ovr0, cs0, sck0, sdi0, ld0;
  logic busy1, fd1, ovr1, cs1, sck1, sdi1, ld1;

  always #5 sysclk = ~sysclk;

  dac_spi_tx dut0 (
    .sysclk(sysclk), .reset(reset), .data_in(data_in), .load(load0),
    .busy(busy0), .frame_done(fd0), .overrun(ovr0),
    .dac_cs_n(cs0), .dac_sck(sck0), .dac_sdi(sdi0), .dac_ld_n(ld0)
  );

  dac_spi_tx #(.CLK_DIV(2)) dut1 (
    .sysclk(sysclk), .reset(reset), .data_in(data_in), .load(load1),
    .busy(busy1), .frame_done(fd1), .overrun(ovr1),
    .dac_cs_n(cs1), .dac_sck(sck1), .dac_sdi(sdi1), .dac_ld_n(ld1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // per-run observations
  int          cs_low, ld_low, fd_cnt, fd_cyc, busy_cnt, nfr, ncs, nrise;
  int          sck_rise0, sck_rise1, sdi_viol, ovr_first;
  logic        ovr_end;
  logic [15:0] fr_word [4];
  int          cs_fall [4];
  logic        snap_cs, snap_sck, snap_sdi, snap_ld, snap_busy;

  task automatic run(input int sel, input int ncyc,
                     input int a0, input logic [9:0] d0,
                     input int a1, input logic [9:0] d1,
                     input int a2, input logic [9:0] d2,
                     input int rst_at, input int snap_at);
    logic p_cs, p_sck, p_sdi;
    logic c_cs, c_sck, c_sdi, c_ld, c_busy, c_fd, c_ovr;
    logic [15:0] sh;
    int nbit;
    cs_low = 0; ld_low = 0; fd_cnt = 0; fd_cyc = -1; busy_cnt = 0; nfr = 0; ncs = 0;
    nrise = 0; sck_rise0 = -1; sck_rise1 = -1; sdi_viol = 0; ovr_first = -1;
    snap_cs = 1'bx; snap_sck = 1'bx; snap_sdi = 1'bx; snap_ld = 1'bx; snap_busy = 1'bx;
    for (int i = 0; i < 4; i++) begin fr_word[i] = '0; cs_fall[i] = -1; end
    p_cs = 1'b1; p_sck = 1'b0; p_sdi = 1'b0; sh = '0; nbit = 0;
    for (int k = 0; k < ncyc; k++) begin
      load0 = 1'b0; load1 = 1'b0;
      reset = (k == rst_at);
      if (k == a0 || k == a1 || k == a2) begin
        data_in = (k == a0) ? d0 : (k == a1) ? d1 : d2;
        if (sel != 0) load1 = 1'b1; else load0 = 1'b1;
      end
      @(posedge sysclk); #1;
      c_cs   = (sel != 0) ? cs1   : cs0;
      c_sck  = (sel != 0) ? sck1  : sck0;
      c_sdi  = (sel != 0) ? sdi1  : sdi0;
      c_ld   = (sel != 0) ? ld1   : ld0;
      c_busy = (sel != 0) ? busy1 : busy0;
      c_fd   = (sel != 0) ? fd1   : fd0;
      c_ovr  = (sel != 0) ? ovr1  : ovr0;
      if (k == snap_at) begin
        snap_cs = c_cs; snap_sck = c_sck; snap_sdi = c_sdi; snap_ld = c_ld; snap_busy = c_busy;
      end
      if (!c_cs) cs_low++;
      if (!c_ld) ld_low++;
      if (c_busy) busy_cnt++;
      if (c_fd) begin fd_cnt++; if (fd_cyc < 0) fd_cyc = k; end
      if (c_ovr && ovr_first < 0) ovr_first = k;
      if (p_sck && c_sck && (p_sdi != c_sdi)) sdi_viol++;
      if (!p_sck && c_sck) begin
        if (nrise == 0) sck_rise0 = k;
        if (nrise == 1) sck_rise1 = k;
        nrise++;
        sh = {sh[14:0], c_sdi};
        nbit++;
      end
      if (p_cs && !c_cs && ncs < 4) begin cs_fall[ncs] = k; ncs++; end
      if (!p_cs && c_cs) begin
        if (nbit == 16 && nfr < 4) begin fr_word[nfr] = sh; nfr++; end
        nbit = 0;
      end
      p_cs = c_cs; p_sck = c_sck; p_sdi = c_sdi;
      ovr_end = c_ovr;
    end
    load0 = 1'b0; load1 = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load0 = 1'b0; load1 = 1'b0; data_in = '0;
    repeat (3) @(posedge sysclk);
    #1;
    n_cmp++; if ({cs0, sck0, sdi0, ld0} !== 4'b1001) begin n_err++;
      $display("FAIL reset_pins: got cs/sck/sdi/ld=%b exp 1001", {cs0, sck0, sdi0, ld0}); end
    n_cmp++; if ({busy0, fd0, ovr0} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags: got busy/done/ovr=%b exp 000", {busy0, fd0, ovr0}); end
    n_cmp++; if ({cs1, sck1, ld1, busy1} !== 4'b1010) begin n_err++;
      $display("FAIL reset_div2: got cs/sck/ld/busy=%b exp 1010", {cs1, sck1, ld1, busy1}); end
    reset = 1'b0;
    @(posedge sysclk); #1;
  endtask

  task automatic test_single_frame();
    run(0, 900, 0, 10'h200, -1, '0, -1, '0, -1, -1);
    n_cmp++; if (nfr !== 1 || fr_word[0] !== 16'h3800) begin n_err++;
      $display("FAIL mid_word: got n=%0d word=%h exp n=1 word=3800", nfr, fr_word[0]); end
    n_cmp++; if (cs_fall[0] !== 0) begin n_err++;
      $display("FAIL cs_latency: got %0d exp 0", cs_fall[0]); end
    n_cmp++; if (cs_low !== 800) begin n_err++;
      $display("FAIL cs_low: got %0d exp 800", cs_low); end
    n_cmp++; if (ld_low !== 25) begin n_err++;
      $display("FAIL ld_low: got %0d exp 25", ld_low); end
    n_cmp++; if (fd_cnt !== 1 || fd_cyc !== 849) begin n_err++;
      $display("FAIL frame_done: got cnt=%0d cyc=%0d exp cnt=1 cyc=849", fd_cnt, fd_cyc); end
    n_cmp++; if (busy_cnt !== 850) begin n_err++;
      $display("FAIL busy_len: got %0d exp 850", busy_cnt); end
    n_cmp++; if (sck_rise0 !== 25 || (sck_rise1 - sck_rise0) !== 50 || nrise !== 16) begin n_err++;
      $display("FAIL sck_timing: got rise0=%0d per=%0d n=%0d exp 25/50/16",
               sck_rise0, sck_rise1 - sck_rise0, nrise); end
    n_cmp++; if (sdi_viol !== 0) begin n_err++;
      $display("FAIL sdi_stable: got %0d changes while sck high exp 0", sdi_viol); end
  endtask

  task automatic test_full_scale();
    run(0, 2000, 0, 10'h3FF, 1000, 10'h000, -1, '0, -1, -1);
    n_cmp++; if (nfr !== 2 || fr_word[0] !== 16'h3FFC || fr_word[1] !== 16'h3000) begin n_err++;
      $display("FAIL fullscale_words: got n=%0d %h %h exp 3ffc 3000", nfr, fr_word[0], fr_word[1]); end
    n_cmp++; if (cs_fall[1] !== 1000) begin n_err++;
      $display("FAIL fullscale_start2: got %0d exp 1000", cs_fall[1]); end
    n_cmp++; if (ovr_end !== 1'b0) begin n_err++;
      $display("FAIL fullscale_overrun: got %b exp 0", ovr_end); end
  endtask

  task automatic test_back_to_back();
    run(0, 1800, 0, 10'h111, 100, 10'h222, 200, 10'h333, -1, -1);
    n_cmp++; if (nfr !== 2 || fr_word[0] !== 16'h3444 || fr_word[1] !== 16'h3CCC) begin n_err++;
      $display("FAIL b2b_words: got n=%0d %h %h exp 3444 3ccc", nfr, fr_word[0], fr_word[1]); end
    n_cmp++; if (cs_fall[1] !== 851) begin n_err++;
      $display("FAIL b2b_gap: got start %0d exp 851", cs_fall[1]); end
    n_cmp++; if (ovr_first !== 200 || ovr_end !== 1'b1) begin n_err++;
      $display("FAIL b2b_overrun: got first=%0d end=%b exp 200/1", ovr_first, ovr_end); end
    n_cmp++; if (fd_cnt !== 2) begin n_err++;
      $display("FAIL b2b_done: got %0d exp 2", fd_cnt); end
  endtask

  task automatic test_mid_reset();
    run(0, 1500, 0, 10'h155, 200, 10'h0F0, -1, '0, 400, 400);
    n_cmp++; if ({snap_cs, snap_sck, snap_sdi, snap_ld, snap_busy} !== 5'b10010) begin n_err++;
      $display("FAIL midrst_pins: got cs/sck/sdi/ld/busy=%b exp 10010",
               {snap_cs, snap_sck, snap_sdi, snap_ld, snap_busy}); end
    n_cmp++; if (cs_low !== 400 || nfr !== 0) begin n_err++;
      $display("FAIL midrst_pending: got cs_low=%0d frames=%0d exp 400/0", cs_low, nfr); end
    n_cmp++; if (ld_low !== 0 || fd_cnt !== 0) begin n_err++;
      $display("FAIL midrst_ldac: got ld_low=%0d done=%0d exp 0/0", ld_low, fd_cnt); end
    n_cmp++; if (ovr_end !== 1'b0) begin n_err++;
      $display("FAIL midrst_overrun: got %b exp 0", ovr_end); end
  endtask

  task automatic test_ldac_load();
    run(0, 1800, 0, 10'h0AB, 850, 10'h2C5, -1, '0, -1, -1);
    n_cmp++; if (fd_cyc !== 849) begin n_err++;
      $display("FAIL ldacload_done: got %0d exp 849", fd_cyc); end
    n_cmp++; if (cs_fall[1] !== 851) begin n_err++;
      $display("FAIL ldacload_gap: got start %0d exp 851", cs_fall[1]); end
    n_cmp++; if (nfr !== 2 || fr_word[0] !== 16'h32AC || fr_word[1] !== 16'h3B14) begin n_err++;
      $display("FAIL ldacload_words: got n=%0d %h %h exp 32ac 3b14", nfr, fr_word[0], fr_word[1]); end
    n_cmp++; if (ovr_end !== 1'b0) begin n_err++;
      $display("FAIL ldacload_overrun: got %b exp 0", ovr_end); end
  endtask

  task automatic test_div2();
    run(1, 100, 0, 10'h2AA, -1, '0, -1, '0, -1, -1);
    n_cmp++; if (nfr !== 1 || fr_word[0] !== 16'h3AA8) begin n_err++;
      $display("FAIL div2_word: got n=%0d %h exp 3aa8", nfr, fr_word[0]); end
    n_cmp++; if (sck_rise0 !== 2 || (sck_rise1 - sck_rise0) !== 4) begin n_err++;
      $display("FAIL div2_sck: got rise0=%0d per=%0d exp 2/4", sck_rise0, sck_rise1 - sck_rise0); end
    n_cmp++; if (busy_cnt !== 68 || cs_low !== 64 || ld_low !== 2) begin n_err++;
      $display("FAIL div2_timing: got busy=%0d cs=%0d ld=%0d exp 68/64/2", busy_cnt, cs_low, ld_low); end
    n_cmp++; if (fd_cnt !== 1 || fd_cyc !== 67) begin n_err++;
      $display("FAIL div2_done: got cnt=%0d cyc=%0d exp 1/67", fd_cnt, fd_cyc); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_full_scale();
    test_back_to_back();
    test_mid_reset();
    test_ldac_load();
    test_div2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
